// File: rtl/das_sum4.sv
// Four-channel delay-and-sum stage: captures one sample set per step into
// per-channel 16-deep circular delay lines and emits the sum of delayed taps.
module das_sum4 #(
    parameter int DATA_W = 16,
    parameter int PTR_W  = 4,
    parameter int CNT_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_samples,
    input  logic [PTR_W-1:0]         delay1,
    input  logic [PTR_W-1:0]         delay2,
    input  logic [PTR_W-1:0]         delay3,
    input  logic [PTR_W-1:0]         delay4,
    input  logic [DATA_W-1:0]        val1,
    input  logic [DATA_W-1:0]        val2,
    input  logic [DATA_W-1:0]        val3,
    input  logic [DATA_W-1:0]        val4,
    output logic                     inc_count,
    output logic [DATA_W+1:0]        beam_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH = 2 ** PTR_W;
    localparam int SUM_W = DATA_W + 2;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_OUTPUT  = 3'd2,
        ST_STEP    = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                 state_q;
    logic [DATA_W-1:0]      line_q [4][DEPTH];
    logic [PTR_W-1:0]       delay_q [4];
    logic [CNT_W-1:0]       num_q;
    logic [CNT_W-1:0]       idx_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [SUM_W-1:0]       beam_q;
    logic                   out_valid_q;
    logic                   inc_count_q;
    logic                   busy_q;
    logic                   done_q;

    logic [DATA_W-1:0]      val_s [4];
    logic [DATA_W-1:0]      tap_s [4];
    logic [PTR_W-1:0]       rd_addr_s [4];
    logic [SUM_W-1:0]       sum_d;

    assign val_s[0] = val1;
    assign val_s[1] = val2;
    assign val_s[2] = val3;
    assign val_s[3] = val4;

    // Tap selection and full-precision sum; a zero delay bypasses the line.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_addr_s[k] = wr_ptr_q - delay_q[k];
            if (delay_q[k] == {PTR_W{1'b0}}) begin
                tap_s[k] = val_s[k];
            end else begin
                tap_s[k] = line_q[k][rd_addr_s[k]];
            end
        end
        sum_d = {{2{tap_s[0][DATA_W-1]}}, tap_s[0]}
              + {{2{tap_s[1][DATA_W-1]}}, tap_s[1]}
              + {{2{tap_s[2][DATA_W-1]}}, tap_s[2]}
              + {{2{tap_s[3][DATA_W-1]}}, tap_s[3]};
    end

    // Control FSM; status outputs are set on entry to the state they mark.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            inc_count_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            beam_q      <= {SUM_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            idx_q       <= {CNT_W{1'b0}};
        end else begin
            inc_count_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_q      <= num_samples;
                        delay_q[0] <= delay1;
                        delay_q[1] <= delay2;
                        delay_q[2] <= delay3;
                        delay_q[3] <= delay4;
                        for (int k = 0; k < 4; k++) begin
                            for (int e = 0; e < DEPTH; e++) begin
                                line_q[k][e] <= {DATA_W{1'b0}};
                            end
                        end
                        wr_ptr_q <= {PTR_W{1'b0}};
                        idx_q    <= {CNT_W{1'b0}};
                        busy_q   <= 1'b1;
                        if (num_samples == {CNT_W{1'b0}}) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_CAPTURE;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    for (int k = 0; k < 4; k++) begin
                        line_q[k][wr_ptr_q] <= val_s[k];
                    end
                    beam_q      <= sum_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == num_q - CNT_ONE) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            inc_count_q <= 1'b1;
                            state_q     <= ST_STEP;
                        end
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    idx_q    <= idx_q + CNT_ONE;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_q <= ST_CAPTURE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign inc_count = inc_count_q;
    assign beam_out  = beam_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_das_sum4.sv
// Self-checking bench for das_sum4: a reader model feeds sample sets and a
// delay-and-sum reference computed from the sample history checks each output.
module tb_das_sum4;

    localparam int DATA_W = 16;
    localparam int PTR_W  = 4;
    localparam int CNT_W  = 10;
    localparam int MAXN   = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_samples = '0;
    logic [PTR_W-1:0]  delay1 = '0, delay2 = '0, delay3 = '0, delay4 = '0;
    logic [DATA_W-1:0] val1 = '0, val2 = '0, val3 = '0, val4 = '0;
    logic              out_ready = 1'b0;
    logic              inc_count, out_valid, busy, done;
    logic [DATA_W+1:0] beam_out;

    int checks = 0;
    int errors = 0;
    int seq [4][MAXN];
    int dl [4];

    das_sum4 #(.DATA_W(DATA_W), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
        .delay1(delay1), .delay2(delay2), .delay3(delay3), .delay4(delay4),
        .val1(val1), .val2(val2), .val3(val3), .val4(val4),
        .inc_count(inc_count), .beam_out(beam_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Delay-and-sum definition: channel k contributes its sample from d_k steps ago.
    function automatic int expected_beam(input int n);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            if (n >= dl[k]) s += seq[k][n - dl[k]];
        end
        return s;
    endfunction

    task automatic drive_vals(input int idx);
        int i;
        i = (idx < MAXN) ? idx : MAXN - 1;
        val1 = 16'(seq[0][i]);
        val2 = 16'(seq[1][i]);
        val3 = 16'(seq[2][i]);
        val4 = 16'(seq[3][i]);
    endtask

    task automatic fill_const(input int c0, input int c1, input int c2, input int c3);
        for (int n = 0; n < MAXN; n++) begin
            seq[0][n] = c0; seq[1][n] = c1; seq[2][n] = c2; seq[3][n] = c3;
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < MAXN; n++) seq[k][n] = n + 1;
    endtask

    task automatic fill_random();
        logic [15:0] r;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < MAXN; n++) begin
                r = 16'($urandom);
                seq[k][n] = int'($signed(r));
            end
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 hold ready low for 5 valid cycles.
    task automatic run(input string tag, input int n, input int ready_mode, input bit glitch);
        int cyc, hs, incs, last_hs, stall, rd, budget;
        bit fin;
        cyc = 0; hs = 0; incs = 0; last_hs = 0; stall = 0; rd = 0; fin = 1'b0;
        budget = n * 40 + 50;
        @(negedge clk);
        num_samples = CNT_W'(n);
        delay1 = PTR_W'(dl[0]); delay2 = PTR_W'(dl[1]);
        delay3 = PTR_W'(dl[2]); delay4 = PTR_W'(dl[3]);
        drive_vals(0);
        start = 1'b1;
        out_ready = (ready_mode == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc <= budget) begin
            if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else if (ready_mode == 2) begin
                if (out_valid) begin out_ready = (stall >= 5); stall++; end
                else begin out_ready = 1'b0; stall = 0; end
            end
            if (inc_count) begin
                incs++;
                rd++;
                drive_vals(rd);
            end
            if (out_valid) begin
                check({tag, " beam"}, int'($signed(beam_out)), expected_beam(hs));
                check({tag, " no_inc_in_output"}, int'(inc_count), 0);
                if (out_ready) begin hs++; last_hs = cyc; end
            end
            if (done) begin
                check({tag, " handshakes"}, hs, n);
                check({tag, " inc_pulses"}, incs, (n == 0) ? 0 : n - 1);
                check({tag, " done_timing"}, cyc, (n == 0) ? 1 : last_hs + 1);
                fin = 1'b1;
            end
            if (!fin) begin
                if (glitch && cyc == 6) begin
                    start = 1'b1;
                    num_samples = CNT_W'(1);
                    delay1 = PTR_W'(dl[0] + 5);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) check({tag, " timeout"}, 0, 1);
        @(negedge clk);
        check({tag, " idle_after_done"}, int'({busy, done, out_valid}), 0);
    endtask

    initial begin
        // Reset held with start asserted
        reset = 1'b0;
        start = 1'b1;
        num_samples = CNT_W'(3);
        repeat (2) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst inc_count", int'(inc_count), 0);
        check("rst done", int'(done), 0);
        check("rst beam", int'(beam_out), 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        fill_const(100, 200, 300, 400);
        set_delays(0, 0, 0, 0);
        run("const", 3, 0, 1'b0);

        fill_ramp();
        set_delays(0, 1, 2, 3);
        run("ramp_delays", 5, 0, 1'b0);

        fill_ramp();
        for (int k = 1; k < 4; k++)
            for (int n = 0; n < MAXN; n++) seq[k][n] = 0;
        set_delays(15, 0, 0, 0);
        run("wrap", 20, 0, 1'b0);

        fill_const(32767, 32767, 32767, 32767);
        set_delays(0, 0, 0, 0);
        run("max", 2, 0, 1'b0);
        fill_const(-32768, -32768, -32768, -32768);
        run("min", 2, 0, 1'b0);

        fill_ramp();
        set_delays(1, 0, 3, 2);
        run("stall", 3, 2, 1'b0);
        run("start_glitch", 4, 0, 1'b1);
        run("zero_len", 0, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            set_delays($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15));
            run("random", $urandom_range(1, 40), 1, 1'b0);
        end

        // Reset asserted while waiting in OUTPUT
        fill_ramp();
        set_delays(0, 0, 0, 0);
        @(negedge clk);
        num_samples = CNT_W'(5);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int w;
            w = 0;
            while (!out_valid && w < 20) begin @(negedge clk); w++; end
            check("midrst reached_output", int'(out_valid), 1);
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst outputs", int'({busy, done, out_valid, inc_count}), 0);
        check("midrst beam", int'(beam_out), 0);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst quiet", int'({busy, inc_count, out_valid}), 0);
        end

        fill_random();
        set_delays(2, 7, 0, 11);
        run("after_reset", 18, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/das_sum4.md
Name: das_sum4

Overview:
- Delay-and-sum stage directly downstream of the 4-channel RF sample reader (val1..val4, advanced by inc_count).
- On each step it captures one 16-bit signed sample per channel into a 16-deep circular delay line.
- It sums the four channel taps, each taken at its own programmable sample delay, and presents one beamformed sample per step on a valid/ready output.
- It drives inc_count back to the reader to fetch the next sample set. It processes num_samples steps per start.

Parameters:
DATA_W, 16, signed sample width per channel
PTR_W, 4, delay-line address width (depth 2**PTR_W = 16)
CNT_W, 10, sample counter width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  begin a run; sampled only in IDLE
num_samples  input  CNT_W  samples in run, latched on start
delay1..delay4  input  PTR_W each  per-channel delay in samples, latched on start
val1..val4  input  DATA_W each  signed channel samples from reader
inc_count  output  1  one-cycle pulse: reader advances to next sample set
beam_out  output  DATA_W+2  signed sum of four delayed taps
out_valid  output  1  beam_out valid
out_ready  input  1  downstream accepts beam_out
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset: while reset=0 at a clock edge:
  - state<=IDLE.
  - inc_count, out_valid, busy and done <= 0; beam_out <= 0.
  - Write pointer and sample index <= 0.
  - Applies from any state, mid-run included. The in-flight output is dropped.
- States: IDLE, CAPTURE, OUTPUT, STEP, SETTLE, DONE.
- IDLE, start=1:
  - Latch num_samples and delay1..4. Clear all 4x16 delay-line entries to 0.
  - Set wr_ptr=0 and idx=0.
  - Next state is CAPTURE, or DONE if num_samples==0.
- start outside IDLE is ignored.
- CAPTURE:
  - Write valK into line K at wr_ptr.
  - Compute tap K = line K at (wr_ptr - delayK) mod 16. delayK=0 bypasses to the current valK.
  - Register the sign-extended 18-bit sum of the four taps into beam_out, set out_valid=1, go to OUTPUT.
  - Samples before the run (n < delayK) contribute 0.
- OUTPUT:
  - Hold beam_out and out_valid stable while out_ready=0.
  - On out_valid&out_ready: out_valid<=0. If idx==num_samples-1, go to DONE; else go to STEP.
- STEP: inc_count=1 for exactly this cycle; wr_ptr<=wr_ptr+1 (wraps 15->0); idx<=idx+1; go to SETTLE.
- SETTLE: one cycle for the reader outputs to update; go to CAPTURE.
- DONE: done=1 for one cycle; go to IDLE.
- Timing: minimum interval is 4 cycles per sample (CAPTURE, OUTPUT, STEP, SETTLE). Latency from the CAPTURE edge to out_valid is 1 cycle.
- Run totals: inc_count pulses exactly num_samples-1 times per run and never in IDLE, DONE or OUTPUT. No pulse on the last sample.
- Arithmetic: signed full-precision sum, 18 bits, never overflows. Range -131072..131068.
- Counters: idx compare uses the latched num_samples. wr_ptr wraps freely, so runs longer than 16 samples are legal.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with start=1 -> busy=0, out_valid=0, inc_count=0, done=0, beam_out=0. Assert reset=0 mid-run in OUTPUT -> all outputs are 0 the next cycle and no further inc_count.
2. Delays all 0, num_samples=3, vals constant 100/200/300/400 -> three handshakes each with beam_out=1000, exactly 2 inc_count pulses, done pulses one cycle after the 3rd handshake.
3. Delays {0,1,2,3}, reader ramp valK[n]=n+1, num_samples=5 -> beam_out sequence 1,3,6,10,14.
4. Wrap: delay1=15, other delays 0 with other vals 0, ramp valK[n]=n+1, num_samples=20 -> beam_out 0 for n=0..14, then 1,2,3,4,5 for n=15..19.
5. Extremes: all vals 0x7FFF, delays 0 -> beam_out=131068 (18'h1FFFC). All vals 0x8000 -> beam_out=-131072 (18'h20000).
6. Handshake/edge cases:
   - out_ready low 5 cycles -> beam_out and out_valid stable, no inc_count.
   - start pulsed while busy -> ignored.
   - num_samples=0 -> done one cycle later, zero inc_count, no out_valid.
